// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// One operation in flight at a time. Normal operations take 32 CALC cycles
// plus one FIX cycle. Divide-by-zero and signed overflow are resolved at
// acceptance and answered one cycle later without leaving IDLE.
module muldiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        kill,
    input  logic [2:0]  funct3,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic        writereg,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [5:0] LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Operation context captured at acceptance
    logic [2:0]  op_reg;
    logic [4:0]  rd_reg;
    logic [31:0] addend_reg;     // multiplicand magnitude, or divisor magnitude
    logic [63:0] acc_reg;        // {product hi, multiplier/product lo} or {remainder, quotient}
    logic        neg_res_reg;    // negate product / quotient in FIX
    logic        neg_rem_reg;    // negate remainder in FIX
    logic [5:0]  count_reg;

    // Special-case answer waiting one cycle before it is presented
    logic        spec_pend_reg;
    logic [31:0] spec_val_reg;
    logic [4:0]  spec_rd_reg;

    // Registered outputs
    logic        done_reg, done_next;
    logic [31:0] result_reg, result_next;
    logic [4:0]  rd_out_reg, rd_out_next;

    // ------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------
    logic        is_div;
    logic        a_signed, b_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, special;
    logic [31:0] special_val;
    logic        accept;

    // Classify the incoming request and form operand magnitudes
    always_comb begin
        is_div   = funct3[2];
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            OP_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; end
            OP_MULHSU: begin a_signed = 1'b1; b_signed = 1'b0; end
            OP_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; end
            OP_REM:    begin a_signed = 1'b1; b_signed = 1'b1; end
            default:   begin a_signed = 1'b0; b_signed = 1'b0; end
        endcase

        a_neg = a_signed & operand_a[31];
        b_neg = b_signed & operand_b[31];
        a_mag = a_neg ? (~operand_a + 32'd1) : operand_a;
        b_mag = b_neg ? (~operand_b + 32'd1) : operand_b;

        // Divide by zero applies to all four divide ops; overflow only to
        // the signed pair DIV/REM (funct3[0] clear).
        div_zero = is_div && (operand_b == 32'd0);
        div_ovf  = is_div && !funct3[0] &&
                   (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;

        special_val = 32'd0;
        if (div_zero) begin
            special_val = funct3[1] ? operand_a : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            special_val = funct3[1] ? 32'd0 : 32'h8000_0000;
        end

        // kill in IDLE drops the request
        accept = (state_reg == IDLE) && start && !kill;
    end

    // ------------------------------------------------------------------
    // One iteration step for each datapath
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_trial;
    logic        div_fits;
    logic [31:0] div_diff;
    logic [63:0] div_step;
    logic [63:0] acc_next;

    // Shift-add multiply and restoring shift-subtract divide, one bit per cycle
    always_comb begin
        // Multiply: add multiplicand to the high half when the current
        // multiplier bit is set, then shift the 65-bit result right.
        mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, addend_reg} : 33'd0);
        mul_step = {mul_sum, acc_reg[31:1]};

        // Divide: bring the next dividend bit into the partial remainder.
        // The remainder stays below the divisor, so when the trial fits the
        // 32-bit difference is exact.
        div_trial = {acc_reg[63:32], acc_reg[31]};
        div_fits  = div_trial >= {1'b0, addend_reg};
        div_diff  = div_trial[31:0] - addend_reg;
        div_step  = div_fits ? {div_diff, acc_reg[30:0], 1'b1}
                             : {div_trial[31:0], acc_reg[30:0], 1'b0};

        acc_next = op_reg[2] ? div_step : mul_step;
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection in FIX
    // ------------------------------------------------------------------
    logic [63:0] product_fixed;
    logic [31:0] quotient_fixed;
    logic [31:0] remainder_fixed;
    logic [31:0] fix_value;

    // Restore signs and pick the architectural result for the latched op
    always_comb begin
        product_fixed   = neg_res_reg ? (~acc_reg + 64'd1) : acc_reg;
        quotient_fixed  = neg_res_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
        remainder_fixed = neg_rem_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];

        case (op_reg)
            OP_MUL:                     fix_value = product_fixed[31:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   fix_value = product_fixed[63:32];
            OP_DIV, OP_DIVU:            fix_value = quotient_fixed;
            OP_REM, OP_REMU:            fix_value = remainder_fixed;
            default:                    fix_value = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && !special) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (kill) begin
                    state_next = IDLE;
                end else if (count_reg == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: what the registered outputs take at the next edge
    always_comb begin
        done_next   = 1'b0;
        result_next = result_reg;
        rd_out_next = rd_out_reg;
        if ((state_reg == FIX) && !kill) begin
            done_next   = 1'b1;
            result_next = fix_value;
            rd_out_next = rd_reg;
        end else if (spec_pend_reg) begin
            done_next   = 1'b1;
            result_next = spec_val_reg;
            rd_out_next = spec_rd_reg;
        end
    end

    // ------------------------------------------------------------------
    // Sequential datapath
    // ------------------------------------------------------------------

    // Capture operation context on acceptance, then iterate during CALC
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_reg      <= 3'd0;
            rd_reg      <= 5'd0;
            addend_reg  <= 32'd0;
            acc_reg     <= 64'd0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            count_reg   <= 6'd0;
        end else begin
            if (accept && !special) begin
                op_reg      <= funct3;
                rd_reg      <= rd_in;
                addend_reg  <= is_div ? b_mag : a_mag;
                acc_reg     <= {32'd0, (is_div ? a_mag : b_mag)};
                neg_res_reg <= a_neg ^ b_neg;
                neg_rem_reg <= a_neg;
                count_reg   <= 6'd0;
            end else if (state_reg == CALC) begin
                acc_reg   <= acc_next;
                count_reg <= count_reg + 6'd1;
            end
        end
    end

    // Hold a special-case answer for one cycle so it appears with 1-cycle latency
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            spec_pend_reg <= 1'b0;
            spec_val_reg  <= 32'd0;
            spec_rd_reg   <= 5'd0;
        end else begin
            spec_pend_reg <= accept && special;
            if (accept && special) begin
                spec_val_reg <= special_val;
                spec_rd_reg  <= rd_in;
            end
        end
    end

    // Output registers; result and rd_out hold until the next completion
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_reg   <= 1'b0;
            result_reg <= 32'd0;
            rd_out_reg <= 5'd0;
        end else begin
            done_reg   <= done_next;
            result_reg <= result_next;
            rd_out_reg <= rd_out_next;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign writereg = done_reg;
    assign result   = result_reg;
    assign rd_out   = rd_out_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vector table, randomized operations
// against a plain-arithmetic reference, and hand-written sequences for
// back-to-back, kill and asynchronous reset behaviour.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic        writereg;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    muldiv_unit dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .kill      (kill),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .writereg  (writereg),
        .result    (result),
        .rd_out    (rd_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // writereg must always mirror done
    always @(negedge clock) begin
        check("writereg_eq_done", {31'd0, writereg}, {31'd0, done});
    end

    // Reference: RV32M results from ordinary 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r = 32'd0;
        case (f)
            3'd0: begin p = 64'(ua * ub); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else begin p = 64'(sa / sb); r = p[31:0]; end
            end
            3'd5: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else begin p = 64'(ua / ub); r = p[31:0]; end
            end
            3'd6: begin
                if (b == 32'd0) r = a;
                else begin p = 64'(sa % sb); r = p[31:0]; end
            end
            default: begin
                if (b == 32'd0) r = a;
                else begin p = 64'(ua % ub); r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    // Cycles from acceptance to done: short-circuit cases answer in 1, others in 33
    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        bit sp;
        sp = f[2] && ((b == 32'd0) ||
                      (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return sp ? 1 : 33;
    endfunction

    // Drive a request at the current (negedge) time; returns at the negedge after E0
    // with operands scrambled so late changes would be visible.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        funct3    = f;
        operand_a = a;
        operand_b = b;
        rd_in     = r;
        kill      = 1'b0;
        start     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start     = 1'b0;
        funct3    = 3'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        rd_in     = 5'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                         input int exp_lat, input bit synced);
        int lat;
        if (!synced) begin
            @(negedge clock);
            check({tag, " idle_no_done"}, {31'd0, done}, 32'd0);
        end
        issue(f, a, b, r);
        check({tag, " early_done"}, {31'd0, done}, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, (exp_lat == 1) ? 32'd0 : 32'd1);
        wait_done(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, r});
        $display("txn %s f3=%0d a=%h b=%h rd=%0d result=%h exp=%h lat=%0d",
                 tag, f, a, b, r, result, exp, lat);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b, saved_res;
        logic [4:0]  saved_rd;
        bit          saw;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd7, 32'd9,          32'd0,         32'd9,         1};
        vecs[14] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[15] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};

        // Reset state
        repeat (3) @(negedge clock);
        check("reset busy",   {31'd0, busy},   32'd0);
        check("reset done",   {31'd0, done},   32'd0);
        check("reset result", result,          32'd0);
        check("reset rd_out", {27'd0, rd_out}, 32'd0);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                  5'(i + 1), vecs[i].exp, vecs[i].lat, 1'b0);
        end

        // Randomized operations against the reference
        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), f, a, b, 5'($urandom), ref_model(f, a, b),
                  ref_latency(f, a, b), 1'b0);
        end

        // Back-to-back: new start in the same cycle as done
        do_op("b2b_first",  3'd0, 32'd5,  32'd6, 5'd6, 32'd30, 33, 1'b0);
        do_op("b2b_second", 3'd5, 32'd50, 32'd5, 5'd7, 32'd10, 33, 1'b1);

        // Two special cases on consecutive edges give done on consecutive cycles
        @(negedge clock);
        funct3 = 3'd5; operand_a = 32'd1; operand_b = 32'd0; rd_in = 5'd1; start = 1'b1;
        @(negedge clock);
        check("spec2 early_done", {31'd0, done}, 32'd0);
        funct3 = 3'd7; operand_a = 32'd9; operand_b = 32'd0; rd_in = 5'd2;
        @(negedge clock);
        start = 1'b0;
        check("spec2 first_done",   {31'd0, done},   32'd1);
        check("spec2 first_result", result,          32'hFFFF_FFFF);
        check("spec2 first_rd",     {27'd0, rd_out}, 32'd1);
        @(negedge clock);
        check("spec2 second_done",   {31'd0, done},   32'd1);
        check("spec2 second_result", result,          32'd9);
        check("spec2 second_rd",     {27'd0, rd_out}, 32'd2);
        @(negedge clock);
        check("spec2 done_drops", {31'd0, done}, 32'd0);
        $display("txn spec_pair results=FFFFFFFF,00000009");

        // Start ignored while busy, then kill mid-divide
        saved_res = result;
        saved_rd  = rd_out;
        issue(3'd4, 32'd1000, 32'd3, 5'd9);
        saw = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (done) saw = 1'b1;
            if (c == 4) begin
                start = 1'b1; funct3 = 3'd0; operand_a = 32'd11; operand_b = 32'd13; rd_in = 5'd3;
            end
            if (c == 5) start = 1'b0;
            if (c == 19) begin
                check("kill busy_before", {31'd0, busy}, 32'd1);
                kill = 1'b1;
            end
            if (c == 20) begin
                kill = 1'b0;
                check("kill busy_after", {31'd0, busy}, 32'd0);
            end
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) saw = 1'b1;
        end
        check("kill no_done", {31'd0, saw},    32'd0);
        check("kill result",  result,          saved_res);
        check("kill rd_out",  {27'd0, rd_out}, {27'd0, saved_rd});
        $display("txn kill_div result=%h rd=%0d", result, rd_out);

        // kill in IDLE drops a start in the same cycle
        @(negedge clock);
        funct3 = 3'd0; operand_a = 32'd2; operand_b = 32'd2; rd_in = 5'd4;
        start = 1'b1; kill = 1'b1;
        @(negedge clock);
        start = 1'b0; kill = 1'b0;
        check("idle_kill busy", {31'd0, busy}, 32'd0);
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) saw = 1'b1;
        end
        check("idle_kill no_done", {31'd0, saw}, 32'd0);
        $display("txn idle_kill dropped busy=%0d", busy);

        do_op("after_kill_mul", 3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 33, 1'b0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clock);
        issue(3'd0, 32'd7, 32'd3, 5'd11);
        repeat (9) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("areset busy",     {31'd0, busy},     32'd0);
        check("areset done",     {31'd0, done},     32'd0);
        check("areset writereg", {31'd0, writereg}, 32'd0);
        check("areset result",   result,            32'd0);
        check("areset rd_out",   {27'd0, rd_out},   32'd0);
        @(negedge clock);
        reset = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clock);
            if (writereg) saw = 1'b1;
        end
        check("areset no_writeback", {31'd0, saw}, 32'd0);
        $display("txn async_reset busy=%0d result=%h", busy, result);

        do_op("after_reset", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0,
              5'd21, ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 33, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
